// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop walk a
// WIDTH-bit operand pair LSB-first, one bit per clock, under start/busy/done.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [WIDTH-1:0] a_shift, b_shift, res_shift;
    logic             c_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg, ovf_reg;
    logic             load, last;
    logic             s_bit, c_out;

    // The single full-adder slice.
    assign s_bit = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign c_out = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

    // Operands shift right; each new sum bit enters the result MSB so that
    // after WIDTH shifts bit 0 has reached position 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi]   = a_reg[gi + 1];
            assign b_shift[gi]   = b_reg[gi + 1];
            assign res_shift[gi] = res_reg[gi + 1];
        end
    endgenerate
    assign a_shift[WIDTH-1]   = 1'b0;
    assign b_shift[WIDTH-1]   = 1'b0;
    assign res_shift[WIDTH-1] = s_bit;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                // Subtraction is a + ~b + 1, so the carry flop starts at 1.
                a_reg   <= a;
                b_reg   <= sub ? ~b : b;
                c_reg   <= sub ? 1'b1 : cin;
                cnt_reg <= '0;
            end else if (state_reg == RUN) begin
                a_reg   <= a_shift;
                b_reg   <= b_shift;
                res_reg <= res_shift;
                c_reg   <= c_out;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // On the last edge c_reg is the carry into the MSB slice.
            if (last) begin
                sum_reg   <= res_shift;
                carry_reg <= c_out;
                ovf_reg   <= c_reg ^ c_out;
            end
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign sum      = sum_reg;
    assign carry    = carry_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 handshake/latency vectors plus an
// exhaustive WIDTH=3 sweep against an arithmetic reference.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, carry, overflow;
    logic [7:0] sum;

    logic       rst3, start3, sub3, cin3;
    logic [2:0] a3, b3;
    logic       busy3, done3, carry3, overflow3;
    logic [2:0] sum3;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .carry(carry3), .overflow(overflow3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one WIDTH=8 operation and follows it to its done edge, checking
    // busy/done/held-sum on every cycle. inj>0 pulses a stray start mid-run.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tcin, input logic tsub, input logic [7:0] prev, input int inj);
        start = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        chk({tag, " start-edge busy/done/sum"}, 32'({busy, done, sum}), 32'({1'b1, 1'b0, prev}));
        for (int i = 1; i <= 7; i++) begin
            if (i == inj) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
            end
            tick();
            start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
            chk($sformatf("%s run%0d busy/done/sum", tag, i),
                32'({busy, done, sum}), 32'({1'b1, 1'b0, prev}));
        end
        tick();
        chk({tag, " done-edge busy/done"}, 32'({busy, done}), 32'({1'b0, 1'b1}));
    endtask

    task automatic res8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        chk({tag, " sum/carry/overflow"}, 32'({sum, carry, overflow}), 32'({es, ec, eo}));
    endtask

    initial begin
        logic       seen_done;
        logic [3:0] full;
        logic [2:0] es;
        logic       ec, eo;
        logic [2:0] ta, tb_;
        int         got;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        rst3 = 1'b1; start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = 3'd0; b3 = 3'd0;
        tick();
        tick();
        chk("reset outputs", 32'({busy, done, sum, carry, overflow}), 32'(0));
        rst = 1'b0;
        rst3 = 1'b0;
        tick();

        op8("add5A+3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 0);
        res8("add5A+3C", 8'h96, 1'b0, 1'b1);
        op8("addFF+01+1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h96, 0);
        res8("addFF+01+1", 8'h01, 1'b1, 1'b0);
        op8("sub10-20", 8'h10, 8'h20, 1'b1, 1'b1, 8'h01, 0);
        res8("sub10-20", 8'hF0, 1'b0, 1'b0);
        op8("sub80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'hF0, 0);
        res8("sub80-01", 8'h7F, 1'b1, 1'b1);
        op8("add11+22 stray-start", 8'h11, 8'h22, 1'b0, 1'b0, 8'h7F, 3);
        res8("add11+22 stray-start", 8'h33, 1'b0, 1'b0);
        op8("add01+02 b2b", 8'h01, 8'h02, 1'b0, 1'b0, 8'h33, 0);
        res8("add01+02 b2b", 8'h03, 1'b0, 1'b0);
        tick();
        chk("idle after done", 32'({busy, done, sum}), 32'({1'b0, 1'b0, 8'h03}));

        // Abort: rst sampled on the edge following the 4th RUN cycle.
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort outputs", 32'({busy, done, sum, carry, overflow}), 32'(0));
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("abort no done", 32'(seen_done), 32'(0));
        op8("add0F+01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 0);
        res8("add0F+01", 8'h10, 1'b0, 1'b0);

        // Exhaustive WIDTH=3 sweep; each operation starts in the previous done cycle.
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 8; x++) begin
                    for (int y = 0; y < 8; y++) begin
                        ta = 3'(x); tb_ = 3'(y);
                        if (s == 1) full = {1'b0, ta} + {1'b0, ~tb_} + 4'd1;
                        else        full = {1'b0, ta} + {1'b0, tb_} + 4'(c);
                        es = full[2:0];
                        ec = full[3];
                        if (s == 1) eo = (ta[2] != tb_[2]) && (es[2] != ta[2]);
                        else        eo = (ta[2] == tb_[2]) && (es[2] != ta[2]);
                        start3 = 1'b1; a3 = ta; b3 = tb_; cin3 = 1'(c); sub3 = 1'(s);
                        tick();
                        start3 = 1'b0;
                        got = 0;
                        for (int n = 1; n <= 6; n++) begin
                            tick();
                            if (done3) begin
                                got = n;
                                break;
                            end
                        end
                        chk($sformatf("w3 sub=%0d cin=%0d a=%0d b=%0d lat/sum/carry/ovf", s, c, x, y),
                            32'({got[3:0], sum3, carry3, overflow3}), 32'({4'd3, es, ec, eo}));
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
